// File: rtl/gate_chk_pkg.sv
// Shared types and truth-table constants for the gate checker.
// Truth tables are indexed by {a,b}; bit0 is a=0,b=0.
package gate_chk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } state_e;

  localparam int TMR_W = 16;

  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;

  function automatic logic tt_bit(
    input logic [3:0] tt,
    input logic [1:0] idx
  );
    return tt[idx];
  endfunction

endpackage

// File: rtl/gate_chk_hold_timer.sv
// Loadable 16-bit down-counter; expire is high while the count is zero.
// Load has priority; the count rests at zero once reached.
module gate_chk_hold_timer
  import gate_chk_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [TMR_W-1:0] cnt_init,
  output logic             expire
);

  logic [TMR_W-1:0] cnt;

  // Reload on request, otherwise count down to zero and stop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= cnt_init;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/gate_truth_checker.sv
// Drives a/b through all four vectors and checks y against TRUTH_TABLE.
// Optional first-fail capture: GATE_CHK_FIRSTFAIL_EN.
module gate_truth_checker
  import gate_chk_pkg::*;
#(
  parameter int         HOLD_CYCLES = 10,
  parameter logic [3:0] TRUTH_TABLE = TT_NOR,
  parameter int         ERR_W       = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       vec_idx
`ifdef GATE_CHK_FIRSTFAIL_EN
  ,
  output logic [1:0]       first_fail_idx,
  output logic             first_fail_vld
`endif
);

  // DRIVE spans HOLD_CYCLES-1 clocks; the timer reaches zero on its last.
  localparam logic [TMR_W-1:0] HOLD_INIT =
    TMR_W'((HOLD_CYCLES >= 2) ? (HOLD_CYCLES - 2) : 0);
  localparam bit SKIP_DRIVE = (HOLD_CYCLES == 1);

  state_e           state;
  logic             load;
  logic             expire;
  logic             mis;
  logic             last_vec;
  logic [ERR_W-1:0] err_next;

  assign a        = vec_idx[1];
  assign b        = vec_idx[0];
  assign last_vec = (vec_idx == 2'd3);
  assign mis      = (y != tt_bit(TRUTH_TABLE, vec_idx));
  assign err_next = (mis && (err_count != '1))
                  ? err_count + 1'b1 : err_count;

  assign load = ((state == IDLE) && start) ||
                ((state == SAMPLE) && !last_vec);

  gate_chk_hold_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .cnt_init (HOLD_INIT),
    .expire   (expire)
  );

  // Run sequencer: steps vectors, accumulates mismatches, reports status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      vec_idx   <= 2'd0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            err_count <= '0;
            pass      <= 1'b0;
            vec_idx   <= 2'd0;
            busy      <= 1'b1;
            state     <= SKIP_DRIVE ? SAMPLE : DRIVE;
          end
        end
        DRIVE: begin
          if (expire) state <= SAMPLE;
        end
        SAMPLE: begin
          err_count <= err_next;
          if (last_vec) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= (err_next == '0);
            vec_idx <= 2'd0;
            state   <= DONE;
          end else begin
            vec_idx <= vec_idx + 2'd1;
            state   <= SKIP_DRIVE ? SAMPLE : DRIVE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GATE_CHK_FIRSTFAIL_EN
  // Capture the index of the first mismatching vector of a run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_fail_idx <= 2'd0;
      first_fail_vld <= 1'b0;
    end else if ((state == IDLE) && start) begin
      first_fail_idx <= 2'd0;
      first_fail_vld <= 1'b0;
    end else if ((state == SAMPLE) && mis && !first_fail_vld) begin
      first_fail_idx <= vec_idx;
      first_fail_vld <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: a NOR gate model with per-vector fault
// injection feeds two checker instances (default and HOLD_CYCLES=1/AND/ERR_W=2).
module tb_gate_truth_checker;
  import gate_chk_pkg::*;

  localparam int H = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       start_f = 1'b0;
  logic [3:0] flip = 4'b0;
  logic [3:0] flip_f = 4'b0;

  logic       a, b, y, busy, done, pass;
  logic [2:0] err;
  logic [1:0] vec;
  logic       a_f, b_f, y_f, busy_f, done_f, pass_f;
  logic [1:0] err_f;
  logic [1:0] vec_f;
`ifdef GATE_CHK_FIRSTFAIL_EN
  logic [1:0] ffi, ffi_f;
  logic       ffv, ffv_f;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign y   = ~(a | b) ^ flip[{a, b}];
  assign y_f = ~(a_f | b_f) ^ flip_f[{a_f, b_f}];

  gate_truth_checker u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a(a), .b(b), .y(y), .busy(busy), .done(done), .pass(pass),
    .err_count(err), .vec_idx(vec)
`ifdef GATE_CHK_FIRSTFAIL_EN
    , .first_fail_idx(ffi), .first_fail_vld(ffv)
`endif
  );

  gate_truth_checker #(
    .HOLD_CYCLES(1), .TRUTH_TABLE(TT_AND), .ERR_W(2)
  ) u_fast (
    .clk(clk), .rst_n(rst_n), .start(start_f),
    .a(a_f), .b(b_f), .y(y_f), .busy(busy_f), .done(done_f),
    .pass(pass_f), .err_count(err_f), .vec_idx(vec_f)
`ifdef GATE_CHK_FIRSTFAIL_EN
    , .first_fail_idx(ffi_f), .first_fail_vld(ffv_f)
`endif
  );

  // Reference: the gate under test is NOR with faults where flip is set.
  function automatic int nor_errs(input logic [3:0] m);
    int c = 0;
    for (int i = 0; i < 4; i++) if (m[i]) c++;
    return c;
  endfunction

  // Errors of a NOR-plus-faults gate checked against an AND table.
  function automatic int and_errs(input logic [3:0] m);
    int c = 0;
    int g, r;
    for (int i = 0; i < 4; i++) begin
      g = ((i == 0) ? 1 : 0) ^ int'(m[i]);
      r = (i == 3) ? 1 : 0;
      if (g != r) c++;
    end
    return c;
  endfunction

  function automatic int first_set(input logic [3:0] m);
    for (int i = 0; i < 4; i++) if (m[i]) return i;
    return 0;
  endfunction

  task automatic test_reset();
    #12;
    n_vec++;
    if ({a, b, busy, done, pass, err, vec} !== 10'b0) begin
      n_bad++;
      $display("FAIL reset_main got %b want 0",
               {a, b, busy, done, pass, err, vec});
    end
    n_vec++;
    if ({a_f, b_f, busy_f, done_f, pass_f, err_f, vec_f} !== 9'b0) begin
      n_bad++;
      $display("FAIL reset_fast got %b want 0",
               {a_f, b_f, busy_f, done_f, pass_f, err_f, vec_f});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_run(input logic [3:0] m, input bit dup);
    int   ee;
    logic [1:0] ev;
    flip = m;
    ee = nor_errs(m);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 4 * H; k++) begin
      ev = 2'((k - 1) / H);
      n_vec++;
      if ({a, b, vec, busy, done} !== {ev[1], ev[0], ev, 1'b1, 1'b0}) begin
        n_bad++;
        $display("FAIL run_cyc%0d a,b,vec,busy,done got %b want %b", k,
                 {a, b, vec, busy, done}, {ev[1], ev[0], ev, 2'b10});
      end
      start = dup && (k == 2 * H + 3);
      @(negedge clk);
    end
    start = 1'b0;
    n_vec++;
    if ({a, b, vec, busy, done, pass, err} !==
        {4'b0, 1'b0, 1'b1, (ee == 0), 3'(ee)}) begin
      n_bad++;
      $display("FAIL run_done mask=%b got %b want %b", m,
               {a, b, vec, busy, done, pass, err},
               {6'b000001, (ee == 0), 3'(ee)});
    end
`ifdef GATE_CHK_FIRSTFAIL_EN
    n_vec++;
    if ({ffv, ffi} !== {(ee != 0), 2'(first_set(m))}) begin
      n_bad++;
      $display("FAIL first_fail mask=%b got %b want %b", m,
               {ffv, ffi}, {(ee != 0), 2'(first_set(m))});
    end
`endif
    @(negedge clk);
    n_vec++;
    if ({busy, done, pass, err} !== {2'b00, (ee == 0), 3'(ee)}) begin
      n_bad++;
      $display("FAIL run_after mask=%b got %b want %b", m,
               {busy, done, pass, err}, {2'b00, (ee == 0), 3'(ee)});
    end
  endtask

  task automatic test_hold_one(input logic [3:0] m);
    int ee;
    ee = and_errs(m);
    if (ee > 3) ee = 3;
    flip_f = m;
    @(negedge clk);
    start_f = 1'b1;
    @(negedge clk);
    start_f = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      n_vec++;
      if ({vec_f, busy_f, done_f} !== {2'(k - 1), 2'b10}) begin
        n_bad++;
        $display("FAIL fast_cyc%0d vec,busy,done got %b want %b", k,
                 {vec_f, busy_f, done_f}, {2'(k - 1), 2'b10});
      end
      @(negedge clk);
    end
    n_vec++;
    if ({vec_f, busy_f, done_f, pass_f, err_f} !==
        {3'b000, 1'b1, (ee == 0), 2'(ee)}) begin
      n_bad++;
      $display("FAIL fast_done mask=%b got %b want %b", m,
               {vec_f, busy_f, done_f, pass_f, err_f},
               {4'b0001, (ee == 0), 2'(ee)});
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midrun();
    flip = 4'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (H + 3) @(negedge clk);
    n_vec++;
    if ({vec, busy} !== 3'b011) begin
      n_bad++;
      $display("FAIL mid_pre vec,busy got %b want 011", {vec, busy});
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({a, b, busy, done, pass, err, vec} !== 10'b0) begin
      n_bad++;
      $display("FAIL mid_reset got %b want 0",
               {a, b, busy, done, pass, err, vec});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4 * H + 5; k++) begin
      @(negedge clk);
      n_vec++;
      if ({busy, done} !== 2'b00) begin
        n_bad++;
        $display("FAIL mid_quiet cyc%0d busy,done got %b want 00",
                 k, {busy, done});
      end
    end
    test_run(4'b0000, 1'b0);
  endtask

  initial begin
    test_reset();
    test_run(4'b0000, 1'b0);
    test_run(4'b1111, 1'b0);
    test_run(4'b0100, 1'b0);
    test_run(4'($urandom_range(1, 15)), 1'b1);
    test_hold_one(4'b0000);
    test_hold_one(4'b1001);
    for (int i = 0; i < 4; i++) test_hold_one(4'($urandom));
    for (int i = 0; i < 4; i++) test_run(4'($urandom), 1'($urandom));
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
